// File: rtl/seg_scan_controller.sv
// Scan scheduler for time-multiplexed seven-segment digits: blanking dead-time, active-low digit selects,
// frame-synchronous display updates. Optional PWM brightness dimming is enabled by SEG_SCAN_BRIGHTNESS_EN.
module seg_scan_controller #(
    parameter int NUM_DIGITS   = 2,
    parameter int DWELL_CYCLES = 60000,
    parameter int BLANK_CYCLES = 600
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    input  logic [4*NUM_DIGITS-1:0] upd_data,
    input  logic [3:0]              bright,
    output logic [3:0]              digit_val,
    output logic [NUM_DIGITS-1:0]   sel,
    output logic                    frame_tick
);

    localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam int IW         = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [CW-1:0]           cnt_r;
    logic [CW-1:0]           cnt_s;
    logic [IW-1:0]           idx_r;
    logic [IW-1:0]           idx_s;
    logic                    boundary_s;
    logic                    entering_on_s;

    logic [4*NUM_DIGITS-1:0] shadow_r;
    logic [4*NUM_DIGITS-1:0] shadow_s;
    logic [4*NUM_DIGITS-1:0] pending_r;
    logic [4*NUM_DIGITS-1:0] pending_s;
    logic                    pending_full_r;
    logic                    pending_full_s;

    logic                    lit_s;
    logic [NUM_DIGITS-1:0]   sel_s;

    logic [NUM_DIGITS-1:0]   sel_r;
    logic [3:0]              digit_val_r;
    logic                    frame_tick_r;
    logic                    upd_ready_r;

    function automatic logic [3:0] nibble_at(input logic [4*NUM_DIGITS-1:0] word,
                                             input logic [IW-1:0]           i);
        logic [3:0] r;
        r = 4'h0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (IW'(k) == i) begin
                r = word[4*k +: 4];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Scan sequencer: dwell/blank timing and digit index advance.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        idx_s         = idx_r;
        boundary_s    = 1'b0;
        entering_on_s = 1'b0;
        case (state_r)
            ST_BLANK: begin
                if (cnt_r == BLANK_LAST) begin
                    state_s       = ST_ON;
                    cnt_s         = CW'(0);
                    entering_on_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            ST_ON: begin
                if (cnt_r == DWELL_LAST) begin
                    state_s = ST_BLANK;
                    cnt_s   = CW'(0);
                    if (idx_r == IDX_LAST) begin
                        idx_s      = IW'(0);
                        boundary_s = 1'b1;
                    end else begin
                        idx_s = idx_r + IW'(1);
                    end
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            default: begin
                state_s = ST_BLANK;
                cnt_s   = CW'(0);
                idx_s   = IW'(0);
            end
        endcase
    end

    // Update path: a full pending buffer blocks new transfers, so commit and load never collide.
    always_comb begin
        shadow_s       = shadow_r;
        pending_s      = pending_r;
        pending_full_s = pending_full_r;
        if (boundary_s && pending_full_r) begin
            shadow_s       = pending_r;
            pending_full_s = 1'b0;
        end else if (upd_valid && !pending_full_r) begin
            pending_s      = upd_data;
            pending_full_s = 1'b1;
        end else begin
            pending_full_s = pending_full_r;
        end
    end

`ifdef SEG_SCAN_BRIGHTNESS_EN
    logic [3:0] pwm_r;
    logic [3:0] pwm_s;

    // PWM phase restarts at every power-on so each visit gets the same duty pattern.
    always_comb begin
        pwm_s = pwm_r;
        if (entering_on_s) begin
            pwm_s = 4'd0;
        end else if (state_r == ST_ON) begin
            pwm_s = pwm_r + 4'd1;
        end else begin
            pwm_s = pwm_r;
        end
        lit_s = ({1'b0, pwm_s} < ({1'b0, bright} + 5'd1));
    end

    // PWM phase register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pwm_r <= 4'd0;
        end else begin
            pwm_r <= pwm_s;
        end
    end
`else
    logic unused_bright_s;

    assign unused_bright_s = ^bright;
    assign lit_s           = 1'b1 | entering_on_s;
`endif

    // Digit power selects for the state being entered.
    always_comb begin
        sel_s = {NUM_DIGITS{1'b1}};
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if ((state_s == ST_ON) && lit_s && (IW'(k) == idx_s)) begin
                sel_s[k] = 1'b0;
            end else begin
                sel_s[k] = 1'b1;
            end
        end
    end

    // Sequencer and update-buffer state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r        <= ST_BLANK;
            cnt_r          <= CW'(0);
            idx_r          <= IW'(0);
            shadow_r       <= {(4*NUM_DIGITS){1'b0}};
            pending_r      <= {(4*NUM_DIGITS){1'b0}};
            pending_full_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            cnt_r          <= cnt_s;
            idx_r          <= idx_s;
            shadow_r       <= shadow_s;
            pending_r      <= pending_s;
            pending_full_r <= pending_full_s;
        end
    end

    // Output registers, loaded from next-state values so they track the state they describe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sel_r        <= {NUM_DIGITS{1'b1}};
            digit_val_r  <= 4'h0;
            frame_tick_r <= 1'b0;
            upd_ready_r  <= 1'b1;
        end else begin
            sel_r        <= sel_s;
            digit_val_r  <= nibble_at(shadow_s, idx_s);
            frame_tick_r <= boundary_s;
            upd_ready_r  <= ~pending_full_s;
        end
    end

    assign sel        = sel_r;
    assign digit_val  = digit_val_r;
    assign frame_tick = frame_tick_r;
    assign upd_ready  = upd_ready_r;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Self-checking bench for seg_scan_controller: randomized updates against a cycle-position reference model.
module tb_seg_scan_controller;

`ifdef SEG_SCAN_BRIGHTNESS_EN
    localparam int DWELL = 32;
`else
    localparam int DWELL = 8;
`endif
    localparam int BLANK = 2;
    localparam int ND    = 2;
    localparam int SLOT  = BLANK + DWELL;
    localparam int FRAME = ND * SLOT;

    logic       clk = 1'b0;
    logic       reset;
    logic       upd_valid;
    logic       upd_ready;
    logic [7:0] upd_data;
    logic [3:0] bright;
    logic [3:0] digit_val;
    logic [1:0] sel;
    logic       frame_tick;

    int errors = 0;
    int checks = 0;
    int t      = 0;

    logic [7:0] m_shadow;
    logic [7:0] m_pending;
    bit         m_full;

    seg_scan_controller #(
        .NUM_DIGITS  (ND),
        .DWELL_CYCLES(DWELL),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .upd_data  (upd_data),
        .bright    (bright),
        .digit_val (digit_val),
        .sel       (sel),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] exp_sel(int tt);
        int         p;
        int         d;
        int         ph;
        logic [1:0] s;
        p  = tt % FRAME;
        d  = p / SLOT;
        ph = p % SLOT;
        s  = 2'b11;
        if (ph >= BLANK) begin
`ifdef SEG_SCAN_BRIGHTNESS_EN
            if (((ph - BLANK) % 16) <= int'(bright)) s[d] = 1'b0;
`else
            s[d] = 1'b0;
`endif
        end
        return s;
    endfunction

    function automatic logic [3:0] exp_digit(int tt);
        int d;
        d = (tt % FRAME) / SLOT;
        return m_shadow[4*d +: 4];
    endfunction

    function automatic logic exp_tick(int tt);
        return (tt > 0) && ((tt % FRAME) == 0);
    endfunction

    task automatic do_reset();
        upd_valid = 1'b0;
        reset     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b1;
        t         = 0;
        m_shadow  = 8'h00;
        m_pending = 8'h00;
        m_full    = 1'b0;
    endtask

    // Apply the clock edge at the end of cycle t to the model, then move to cycle t+1.
    task automatic advance();
        bit boundary;
        bit was_full;
        boundary = (((t + 1) % FRAME) == 0);
        was_full = m_full;
        if (boundary && was_full) begin
            m_shadow = m_pending;
            m_full   = 1'b0;
        end
        if (upd_valid && !was_full) begin
            m_pending = upd_data;
            m_full    = 1'b1;
        end
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic advance_to(int pos);
        for (int i = 0; i < FRAME && (t % FRAME) != pos; i++) advance();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (sel !== 2'b11) begin errors++; $display("FAIL reset_sel got=%b exp=11", sel); end
        checks++; if (digit_val !== 4'h0) begin errors++; $display("FAIL reset_digit got=%h exp=0", digit_val); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", frame_tick); end
        checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", upd_ready); end
    endtask

    task automatic test_idle_frame();
        int first_tick;
        first_tick = -1;
        for (int c = 0; c <= 2 * FRAME; c++) begin
            checks++; if (sel !== exp_sel(t)) begin errors++; $display("FAIL idle_sel t=%0d got=%b exp=%b", t, sel, exp_sel(t)); end
            checks++; if (frame_tick !== exp_tick(t)) begin errors++; $display("FAIL idle_tick t=%0d got=%b exp=%b", t, frame_tick, exp_tick(t)); end
            checks++; if (digit_val !== 4'h0) begin errors++; $display("FAIL idle_digit t=%0d got=%h exp=0", t, digit_val); end
            checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL idle_ready t=%0d got=%b exp=1", t, upd_ready); end
            if (frame_tick === 1'b1 && first_tick < 0) first_tick = t;
            advance();
        end
        checks++; if (first_tick != FRAME) begin errors++; $display("FAIL first_tick got=%0d exp=%0d", first_tick, FRAME); end
    endtask

    task automatic test_update();
        int tick_seen;
        tick_seen = 0;
        advance_to(SLOT + BLANK + 1);
        upd_data  = 8'h5A;
        upd_valid = 1'b1;
        advance();
        upd_valid = 1'b0;
        upd_data  = 8'($urandom);
        for (int c = 0; c < 2 * FRAME; c++) begin
            if (frame_tick === 1'b1) tick_seen++;
            checks++; if (upd_ready !== ((tick_seen > 0) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL upd_ready t=%0d got=%b ticks=%0d", t, upd_ready, tick_seen); end
            checks++; if (digit_val !== exp_digit(t)) begin errors++; $display("FAIL upd_digit t=%0d got=%h exp=%h", t, digit_val, exp_digit(t)); end
            if (tick_seen > 0 && sel === 2'b10) begin
                checks++; if (digit_val !== 4'hA) begin errors++; $display("FAIL upd_digit0 t=%0d got=%h exp=a", t, digit_val); end
            end
            if (tick_seen > 0 && sel === 2'b01) begin
                checks++; if (digit_val !== 4'h5) begin errors++; $display("FAIL upd_digit1 t=%0d got=%h exp=5", t, digit_val); end
            end
            advance();
        end
    endtask

    task automatic test_pending_full();
        logic [7:0] second;
        int         ticks;
        int         pos_checks;
        second     = 8'h00;
        ticks      = 0;
        pos_checks = 0;
        advance_to(BLANK + 2);
        upd_valid = 1'b1;
        upd_data  = 8'($urandom);
        advance();
        for (int c = 0; c < FRAME + 2; c++) begin
            upd_data = 8'($urandom);
            checks++; if (upd_ready !== !m_full) begin errors++; $display("FAIL busy_ready t=%0d got=%b exp=%b", t, upd_ready, !m_full); end
            if (frame_tick === 1'b1) begin
                ticks++;
                second = upd_data;
                checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL ready_with_tick t=%0d got=%b exp=1", t, upd_ready); end
            end
            advance();
        end
        upd_valid = 1'b0;
        checks++; if (ticks != 1) begin errors++; $display("FAIL busy_ticks got=%0d exp=1", ticks); end
        checks++; if (upd_ready !== 1'b0) begin errors++; $display("FAIL second_accepted got=%b exp=0", upd_ready); end
        ticks = 0;
        for (int c = 0; c < 2 * FRAME && pos_checks < 2; c++) begin
            if (frame_tick === 1'b1) ticks++;
            checks++; if (digit_val !== exp_digit(t)) begin errors++; $display("FAIL busy_digit t=%0d got=%h exp=%h", t, digit_val, exp_digit(t)); end
            if (ticks > 0 && (t % FRAME) == BLANK) begin
                pos_checks++;
                checks++; if (digit_val !== second[3:0]) begin errors++; $display("FAIL second_lo t=%0d got=%h exp=%h", t, digit_val, second[3:0]); end
            end
            if (ticks > 0 && (t % FRAME) == SLOT + BLANK) begin
                pos_checks++;
                checks++; if (digit_val !== second[7:4]) begin errors++; $display("FAIL second_hi t=%0d got=%h exp=%h", t, digit_val, second[7:4]); end
            end
            advance();
        end
        checks++; if (pos_checks != 2) begin errors++; $display("FAIL second_timeout got=%0d exp=2", pos_checks); end
    endtask

    task automatic test_reset_mid_on();
        advance_to(1);
        upd_valid = 1'b1;
        upd_data  = 8'($urandom_range(1, 255));
        advance();
        upd_valid = 1'b0;
        advance_to(SLOT + BLANK + 3);
        checks++; if (upd_ready !== 1'b0) begin errors++; $display("FAIL pre_reset_ready got=%b exp=0", upd_ready); end
        checks++; if (sel !== 2'b01) begin errors++; $display("FAIL pre_reset_sel got=%b exp=01", sel); end
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (sel !== 2'b11) begin errors++; $display("FAIL mid_reset_sel got=%b exp=11", sel); end
        checks++; if (digit_val !== 4'h0) begin errors++; $display("FAIL mid_reset_digit got=%h exp=0", digit_val); end
        checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got=%b exp=1", upd_ready); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL mid_reset_tick got=%b exp=0", frame_tick); end
        reset     = 1'b1;
        t         = 0;
        m_shadow  = 8'h00;
        m_pending = 8'h00;
        m_full    = 1'b0;
        for (int c = 0; c < FRAME + SLOT; c++) begin
            checks++; if (sel !== exp_sel(t)) begin errors++; $display("FAIL restart_sel t=%0d got=%b exp=%b", t, sel, exp_sel(t)); end
            checks++; if (frame_tick !== exp_tick(t)) begin errors++; $display("FAIL restart_tick t=%0d got=%b exp=%b", t, frame_tick, exp_tick(t)); end
            checks++; if (digit_val !== 4'h0) begin errors++; $display("FAIL discarded t=%0d got=%h exp=0", t, digit_val); end
            advance();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 6 * FRAME; c++) begin
            upd_valid = ($urandom_range(0, 3) == 0);
            upd_data  = 8'($urandom);
`ifndef SEG_SCAN_BRIGHTNESS_EN
            bright    = 4'($urandom);
`endif
            checks++; if (sel !== exp_sel(t)) begin errors++; $display("FAIL rnd_sel t=%0d got=%b exp=%b", t, sel, exp_sel(t)); end
            checks++; if (digit_val !== exp_digit(t)) begin errors++; $display("FAIL rnd_digit t=%0d got=%h exp=%h", t, digit_val, exp_digit(t)); end
            checks++; if (frame_tick !== exp_tick(t)) begin errors++; $display("FAIL rnd_tick t=%0d got=%b exp=%b", t, frame_tick, exp_tick(t)); end
            checks++; if (upd_ready !== !m_full) begin errors++; $display("FAIL rnd_ready t=%0d got=%b exp=%b", t, upd_ready, !m_full); end
            checks++; if ($countones(~sel) > 1) begin errors++; $display("FAIL rnd_onehot t=%0d got=%b", t, sel); end
            advance();
        end
        upd_valid = 1'b0;
    endtask

`ifdef SEG_SCAN_BRIGHTNESS_EN
    task automatic test_brightness();
        int lows;
        int exp_lows;
        for (int k = 0; k < 2; k++) begin
            bright   = (k == 0) ? 4'd3 : 4'd15;
            exp_lows = (k == 0) ? 8 : 32;
            do_reset();
            lows = 0;
            for (int c = 0; c < FRAME; c++) begin
                checks++; if (sel !== exp_sel(t)) begin errors++; $display("FAIL pwm_sel t=%0d got=%b exp=%b", t, sel, exp_sel(t)); end
                if (sel[0] === 1'b0) lows++;
                advance();
            end
            checks++; if (lows != exp_lows) begin errors++; $display("FAIL pwm_duty bright=%0d got=%0d exp=%0d", bright, lows, exp_lows); end
        end
    endtask
`endif

    initial begin
        reset     = 1'b0;
        upd_valid = 1'b0;
        upd_data  = 8'h00;
`ifdef SEG_SCAN_BRIGHTNESS_EN
        bright    = 4'd15;
`else
        bright    = 4'($urandom);
`endif
        test_reset();
        test_idle_frame();
        test_update();
        test_pending_full();
        test_reset_mid_on();
        test_random();
`ifdef SEG_SCAN_BRIGHTNESS_EN
        test_brightness();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
